muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// Holds the op encoding, FSM states, iteration count and a magnitude helper.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } muldiv_state_t;

    localparam int MULDIV_ITER = 32;

    function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// {upper,lower} is the partial product or the remainder:dividend pair.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        isDiv,
    input  logic [31:0] upper,
    input  logic [31:0] lower,
    input  logic [31:0] operand,
    output logic [31:0] nextUpper,
    output logic [31:0] nextLower
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;

    always_comb begin
        sum       = {1'b0, upper} + (lower[0] ? {1'b0, operand} : 33'd0);
        shifted   = {upper, lower[31]};
        // Remainder stays below the divisor, so the difference fits in 32 bits
        diff      = shifted[31:0] - operand;
        nextUpper = sum[32:1];
        nextLower = {sum[0], lower[31:1]};
        if (isDiv) begin
            if (shifted >= {1'b0, operand}) begin
                nextUpper = diff;
                nextLower = {lower[30:0], 1'b1};
            end else begin
                nextUpper = shifted[31:0];
                nextLower = {lower[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage HI/LO unit: iterative MULT/DIV over magnitudes with sign fix-up,
// MFxx/MTxx access and hazard stall generation.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  muldiv_op_t  Op,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        Stall,
    input  logic        Flush,
    output logic [31:0] Result,
    output logic        ALUStall,
    output logic        Busy
);

    muldiv_state_t state, nextState;

    logic [5:0]  count;
    logic [31:0] hi, lo;
    logic [31:0] upperReg, lowerReg, operandReg, rsLatch;
    logic        negHi, negLo;
    logic [31:0] nextUpper, nextLower;

    logic        isMulOp, isDivOp, isSigned, idleWrite, accept, done;
    logic [31:0] rsAbs, rtAbs;
    logic [63:0] product;
    logic [31:0] quoFinal, remFinal;

    always_comb begin
        isMulOp   = (Op == OP_MULT) || (Op == OP_MULTU);
        isDivOp   = (Op == OP_DIV) || (Op == OP_DIVU);
        isSigned  = (Op == OP_MULT) || (Op == OP_DIV);
        idleWrite = (state == IDLE) && !Stall && !Flush;
        accept    = idleWrite && (isMulOp || isDivOp);
        done      = (state != IDLE) && (count == 6'(MULDIV_ITER - 1));
        rsAbs     = absVal(RsData, isSigned);
        rtAbs     = absVal(RtData, isSigned);
    end

    muldiv_step uStep (
        .isDiv     (state == DIV),
        .upper     (upperReg),
        .lower     (lowerReg),
        .operand   (operandReg),
        .nextUpper (nextUpper),
        .nextLower (nextLower)
    );

    // Sign correction applied to the final iteration's output
    always_comb begin
        product  = {nextUpper, nextLower};
        if (negHi) product = -product;
        quoFinal = negLo ? -nextLower : nextLower;
        remFinal = negHi ? -nextUpper : nextUpper;
        if (operandReg == 32'd0) begin
            quoFinal = 32'hFFFF_FFFF;
            remFinal = rsLatch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (accept) nextState = isMulOp ? MUL : DIV;
            MUL,
            DIV:     if (Flush || done) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= 6'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            upperReg   <= 32'd0;
            lowerReg   <= 32'd0;
            operandReg <= 32'd0;
            rsLatch    <= 32'd0;
            negHi      <= 1'b0;
            negLo      <= 1'b0;
        end else begin
            if (accept) begin
                count      <= 6'd0;
                upperReg   <= 32'd0;
                lowerReg   <= isMulOp ? rtAbs : rsAbs;
                operandReg <= isMulOp ? rsAbs : rtAbs;
                rsLatch    <= RsData;
                negLo      <= isSigned && (RsData[31] ^ RtData[31]);
                negHi      <= isSigned && (isMulOp ? (RsData[31] ^ RtData[31]) : RsData[31]);
            end else if (state != IDLE && !Flush) begin
                count    <= count + 6'd1;
                upperReg <= nextUpper;
                lowerReg <= nextLower;
                if (done) begin
                    hi <= (state == MUL) ? product[63:32] : remFinal;
                    lo <= (state == MUL) ? product[31:0]  : quoFinal;
                end
            end
            if (idleWrite && Op == OP_MTHI) hi <= RsData;
            if (idleWrite && Op == OP_MTLO) lo <= RsData;
        end
    end

    always_comb begin
        Busy     = !reset && (state != IDLE);
        ALUStall = Busy && (Op != OP_NONE);
        Result   = 32'd0;
        if (!reset && Op == OP_MFHI) Result = hi;
        if (!reset && Op == OP_MFLO) Result = lo;
    end

endmodule
